// File: rtl/hdmi_dbg_pkg.sv
// hdmi_dbg_pkg
// Shared constants for the HDMI debug pattern generator and marker controller:
// command opcodes, FSM state encoding, raster timing/active-window constants and
// the saturating clamp helper used by the marker arithmetic.
// Ports: none (package).

package hdmi_dbg_pkg;

    // Marker command opcodes
    typedef enum logic [2:0] {
        OpNop    = 3'd0,
        OpLeft   = 3'd1,
        OpRight  = 3'd2,
        OpUp     = 3'd3,
        OpDown   = 3'd4,
        OpSet    = 3'd5,
        OpCenter = 3'd6
    } op_e;

    // Marker controller FSM
    typedef enum logic {
        StIdle = 1'b0,
        StExec = 1'b1
    } ctrl_state_e;

    // Raster timing of the pattern generator
    localparam int unsigned HTotal     = 800;
    localparam int unsigned VTotal     = 525;
    localparam int unsigned ColActMin  = 144;
    localparam int unsigned ColActMax  = 783;
    localparam int unsigned LineActMin = 36;
    localparam int unsigned LineActMax = 515;
    localparam int unsigned ColCenter  = 464;
    localparam int unsigned LineCenter = 276;

    // Clamp a signed 17-bit intermediate into [lo, hi]; bounds are always positive.
    function automatic logic [15:0] sat17(logic signed [16:0] v,
                                          logic signed [16:0] lo,
                                          logic signed [16:0] hi);
        logic signed [16:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r[15:0];
    endfunction

endpackage

// File: rtl/hdmi_marker_ctrl_if.sv
// hdmi_marker_ctrl_if
// Command bus between the two marker requesters and the marker controller.
// Signals:
//   req_valid  [1:0]  per-requester command valid
//   req_cmd0/1 [2:0]  opcode (see hdmi_dbg_pkg::op_e)
//   req_step0/1 [7:0] step for relative moves
//   req_col0/1, req_line0/1 [15:0] absolute target for SET
//   req_ready  [1:0]  one-cycle acknowledge per requester
// Modports: master (requester side), slave (controller side).

interface hdmi_marker_ctrl_if;

    logic [1:0]  req_valid;
    logic [2:0]  req_cmd0;
    logic [2:0]  req_cmd1;
    logic [7:0]  req_step0;
    logic [7:0]  req_step1;
    logic [15:0] req_col0;
    logic [15:0] req_col1;
    logic [15:0] req_line0;
    logic [15:0] req_line1;
    logic [1:0]  req_ready;

    modport master (
        output req_valid, req_cmd0, req_cmd1, req_step0, req_step1,
               req_col0, req_col1, req_line0, req_line1,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_cmd0, req_cmd1, req_step0, req_step1,
               req_col0, req_col1, req_line0, req_line1,
        output req_ready
    );

endinterface

// File: rtl/marker_sat_alu.sv
// marker_sat_alu
// Combinational saturating update of one marker axis.
// Ports:
//   i_dec    subtract step, clamp at MinVal
//   i_inc    add step, clamp at MaxVal
//   i_set    load i_abs clamped into [MinVal, MaxVal]
//   i_center load RstVal
//   i_cur    current shadow value
//   i_step   relative step
//   i_abs    absolute target
//   o_nxt    next shadow value (i_cur when no operation selected)

module marker_sat_alu
    import hdmi_dbg_pkg::*;
#(
    parameter int unsigned MinVal = 144,
    parameter int unsigned MaxVal = 783,
    parameter int unsigned RstVal = 464
) (
    input  logic        i_dec,
    input  logic        i_inc,
    input  logic        i_set,
    input  logic        i_center,
    input  logic [15:0] i_cur,
    input  logic [7:0]  i_step,
    input  logic [15:0] i_abs,
    output logic [15:0] o_nxt
);

    localparam logic signed [16:0] LimMin = 17'(MinVal);
    localparam logic signed [16:0] LimMax = 17'(MaxVal);

    logic signed [16:0] w_cur;
    logic signed [16:0] w_step;
    logic signed [16:0] w_abs;
    logic signed [16:0] w_sum;
    logic signed [16:0] w_diff;

    assign w_cur  = signed'({1'b0, i_cur});
    assign w_step = signed'({9'd0, i_step});
    assign w_abs  = signed'({1'b0, i_abs});
    assign w_sum  = w_cur + w_step;
    assign w_diff = w_cur - w_step;

    always_comb begin
        o_nxt = i_cur;
        if (i_center) begin
            o_nxt = 16'(RstVal);
        end else if (i_set) begin
            o_nxt = sat17(w_abs, LimMin, LimMax);
        end else if (i_dec) begin
            o_nxt = sat17(w_diff, LimMin, LimMax);
        end else if (i_inc) begin
            o_nxt = sat17(w_sum, LimMin, LimMax);
        end
    end

endmodule

// File: rtl/hdmi_marker_ctrl.sv
// hdmi_marker_ctrl
// Marker-position controller: round-robin arbitration of two requesters, saturating
// update of a shadow position, and tear-free commit of the shadow to colom/Line on
// the falling edge of VSync.
// Ports:
//   clk, rstn    pixel clock, async active-low reset
//   vsync_in     generator VSync (active low)
//   freeze       blocks commits while high
//   req_if       command bus (slave modport)
//   colom, Line  committed marker position
//   dirty        shadow differs from committed, commit pending
//   commit       one-cycle pulse per commit
//   commit_cnt   wrapping commit counter

module hdmi_marker_ctrl
    import hdmi_dbg_pkg::*;
#(
    parameter int unsigned COL_MIN  = ColActMin,
    parameter int unsigned COL_MAX  = ColActMax,
    parameter int unsigned LINE_MIN = LineActMin,
    parameter int unsigned LINE_MAX = LineActMax,
    parameter int unsigned COL_RST  = ColCenter,
    parameter int unsigned LINE_RST = LineCenter
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                vsync_in,
    input  logic                freeze,
    hdmi_marker_ctrl_if.slave   req_if,
    output logic [15:0]         colom,
    output logic [15:0]         Line,
    output logic                dirty,
    output logic                commit,
    output logic [15:0]         commit_cnt
);

    ctrl_state_e r_state;
    ctrl_state_e w_state_d;
    logic        r_grant;
    logic        w_grant_d;
    logic        r_last;
    logic        w_last_d;
    logic [1:0]  w_ready;

    logic        r_vsync;
    logic [15:0] r_sh_col;
    logic [15:0] r_sh_line;
    logic [15:0] r_col;
    logic [15:0] r_line;
    logic [15:0] r_cnt;
    logic        r_dirty;
    logic        r_commit;

    logic        w_exec;
    logic [2:0]  w_cmd;
    logic [7:0]  w_step;
    logic [15:0] w_abs_col;
    logic [15:0] w_abs_line;
    logic [15:0] w_col_nxt;
    logic [15:0] w_line_nxt;
    logic        w_vsync_fall;
    logic        w_commit;
    logic [15:0] w_com_col_d;
    logic [15:0] w_com_line_d;
    logic        w_dirty_d;

    // FSM / arbiter next state
    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
        w_last_d  = r_last;
        w_ready   = 2'b00;
        unique case (r_state)
            StIdle: begin
                if (|req_if.req_valid) begin
                    // On a tie the requester not served last wins
                    w_grant_d = (&req_if.req_valid) ? ~r_last : req_if.req_valid[1];
                    w_last_d  = w_grant_d;
                    w_state_d = StExec;
                end
            end
            StExec: begin
                w_ready[r_grant] = 1'b1;
                w_state_d        = StIdle;
            end
        endcase
    end

    assign req_if.req_ready = w_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
            r_last  <= w_last_d;
        end
    end

    // Granted command fields, sampled during EXEC
    assign w_exec     = (r_state == StExec);
    assign w_cmd      = r_grant ? req_if.req_cmd1  : req_if.req_cmd0;
    assign w_step     = r_grant ? req_if.req_step1 : req_if.req_step0;
    assign w_abs_col  = r_grant ? req_if.req_col1  : req_if.req_col0;
    assign w_abs_line = r_grant ? req_if.req_line1 : req_if.req_line0;

    marker_sat_alu #(
        .MinVal (COL_MIN),
        .MaxVal (COL_MAX),
        .RstVal (COL_RST)
    ) u_alu_col (
        .i_dec    (w_cmd == OpLeft),
        .i_inc    (w_cmd == OpRight),
        .i_set    (w_cmd == OpSet),
        .i_center (w_cmd == OpCenter),
        .i_cur    (r_sh_col),
        .i_step   (w_step),
        .i_abs    (w_abs_col),
        .o_nxt    (w_col_nxt)
    );

    marker_sat_alu #(
        .MinVal (LINE_MIN),
        .MaxVal (LINE_MAX),
        .RstVal (LINE_RST)
    ) u_alu_line (
        .i_dec    (w_cmd == OpUp),
        .i_inc    (w_cmd == OpDown),
        .i_set    (w_cmd == OpSet),
        .i_center (w_cmd == OpCenter),
        .i_cur    (r_sh_line),
        .i_step   (w_step),
        .i_abs    (w_abs_line),
        .o_nxt    (w_line_nxt)
    );

    // Commit logic: a commit in the same cycle as EXEC takes the pre-update shadow
    assign w_vsync_fall = r_vsync & ~vsync_in;
    assign w_commit     = w_vsync_fall & r_dirty & ~freeze;
    assign w_com_col_d  = w_commit ? r_sh_col  : r_col;
    assign w_com_line_d = w_commit ? r_sh_line : r_line;

    always_comb begin
        w_dirty_d = r_dirty;
        if (w_exec && ((w_col_nxt != w_com_col_d) || (w_line_nxt != w_com_line_d))) begin
            w_dirty_d = 1'b1;
        end else if (w_commit) begin
            w_dirty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vsync   <= 1'b1;
            r_sh_col  <= 16'(COL_RST);
            r_sh_line <= 16'(LINE_RST);
            r_col     <= 16'(COL_RST);
            r_line    <= 16'(LINE_RST);
            r_cnt     <= 16'd0;
            r_dirty   <= 1'b0;
            r_commit  <= 1'b0;
        end else begin
            r_vsync  <= vsync_in;
            r_dirty  <= w_dirty_d;
            r_commit <= w_commit;
            r_col    <= w_com_col_d;
            r_line   <= w_com_line_d;
            if (w_commit) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_exec) begin
                r_sh_col  <= w_col_nxt;
                r_sh_line <= w_line_nxt;
            end
        end
    end

    assign colom      = r_col;
    assign Line       = r_line;
    assign dirty      = r_dirty;
    assign commit     = r_commit;
    assign commit_cnt = r_cnt;

endmodule

// File: doc/hdmi_marker_ctrl.md
# hdmi_marker_ctrl

Marker-position controller for the HDMI debug pattern generator. It accepts cursor-move commands from two requesters over valid/ready handshakes and arbitrates between them round-robin. Each command is applied with saturating arithmetic to a shadow position, and the shadow is committed to the generator's `colom`/`Line` inputs only at the start of vertical sync, so the white marker pixel never tears mid-frame.

## Interface
Parameters:
- `COL_MIN`, 144: first active column (generator Hsync count).
- `COL_MAX`, 783: last active column.
- `LINE_MIN`, 36: first active line.
- `LINE_MAX`, 515: last active line.
- `COL_RST`, 464: reset/center column.
- `LINE_RST`, 276: reset/center line.

Ports:
- `clk`  in  1  pixel clock, shared with the pattern generator.
- `rstn`  in  1  asynchronous, active-low reset.
- `vsync_in`  in  1  generator VSync, active low.
- `freeze`  in  1  suppresses commits while high.
- `req_valid`  in  2  per-requester command valid.
- `req_cmd0`, `req_cmd1`  in  3  opcode: 0 NOP, 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN, 5 SET, 6 CENTER.
- `req_step0`, `req_step1`  in  8  step for relative moves.
- `req_col0`, `req_col1`, `req_line0`, `req_line1`  in  16  absolute target for SET.
- `req_ready`  out  2  one-cycle acknowledge per requester.
- `colom`  out  16  committed marker column.
- `Line`  out  16  committed marker line.
- `dirty`  out  1  shadow differs from committed, pending commit.
- `commit`  out  1  one-cycle pulse on each commit.
- `commit_cnt`  out  16  number of commits, wraps.

## Operation
- FSM states and transitions:
  - IDLE: if any `req_valid` is high, register the grant and go to EXEC.
  - EXEC: update the shadow from the granted command, assert `req_ready[grant]`, return to IDLE.
- Arbitration is round-robin on pointer `last`. With both requesters valid, grant `~last`; with one valid, grant it. `last` updates on each grant and resets to 1, so requester 0 wins the first tie.
- Command fields are sampled in EXEC. A requester must hold valid and its fields stable until it sees ready. Valid deasserted before ready still completes the granted command.
- Arithmetic is done on 17-bit signed intermediates, then saturated:
  - LEFT/UP subtract the step; results below MIN clamp to MIN.
  - RIGHT/DOWN add the step; results above MAX clamp to MAX.
  - SET clamps each field independently into [MIN, MAX].
  - CENTER loads `COL_RST`/`LINE_RST`.
  - NOP and step 0 leave the shadow unchanged but are still acknowledged.
- `dirty` sets whenever EXEC writes a shadow value different from the committed position.
- Commit event is `vsync_fall` (registered `vsync_in` high, current low), with `dirty` high and `freeze` low. On a commit:
  - `colom`/`Line` load the shadow.
  - `dirty` clears.
  - `commit` pulses.
  - `commit_cnt` increments, wrapping 0xFFFF to 0.
- `freeze` high at `vsync_fall`: no commit, `dirty` held. The next unfrozen fall commits.

## Timing
- Reset values:
  - outputs: `colom`=`COL_RST`, `Line`=`LINE_RST`, `req_ready`=0, `dirty`=0, `commit`=0, `commit_cnt`=0.
  - internal: shadow = committed position, FSM=IDLE, `last`=1, vsync delay register=1.
- Latency: valid first seen in IDLE at cycle N gives ready high in cycle N+1. The shadow is updated at the end of N+1.
- Throughput: one command per 2 cycles. Back-to-back valids from both requesters alternate grants.
- Commit timing: `colom`/`Line` change on the clock edge after the cycle in which `vsync_fall` is detected, i.e. 2 edges after `vsync_in` falls. The generator holds VSync low for 1600 cycles, so the update lands in blanking.
- Simultaneous EXEC and `vsync_fall`: the commit takes the pre-update shadow. `dirty` stays 1 if the new value differs, and the next frame commits it.
- Reset asserted mid-EXEC: the command is dropped with no ready; everything returns to reset values immediately, asynchronously.

## Structure
- Shared package `hdmi_dbg_pkg` holds:
  - opcode constants.
  - timing constants (800 columns/line, 525 lines, active windows).
- One natural sub-module, `marker_sat_alu`: a combinational saturating add/sub/clamp for one axis, instantiated twice (column, line).
- The FSM, arbiter and commit logic stay in the top.

## Test plan
- Reset release, no requests → `colom`=464, `Line`=276, `commit_cnt`=0, `dirty`=0, through two frames.
- Req0 RIGHT step 10, then a vsync fall → `req_ready`=01 one cycle after valid; `colom`=474 two edges after the fall; `commit`=1 for one cycle; `commit_cnt`=1.
- Both valid (req0 LEFT 5, req1 UP 5) from reset → grants in order req0 then req1; shadow ends at 459/271; ready pulses 2 cycles apart.
- Saturation → SET col 0/line 9999 gives 144/515; then LEFT 255 stays 144; DOWN 1 stays 515.
- `freeze`=1 across one vsync fall with `dirty`=1 → no commit and `dirty` held; next fall with `freeze`=0 commits.
- EXEC coinciding with a vsync fall → old shadow committed, `dirty`=1 afterwards, new value committed on the following frame. Separately, `rstn` pulsed mid-EXEC → no ready, all outputs at reset values.
